dlfloat_dot_engine: RTL

//  Streaming DLFloat16 dot-product engine (1-6-9 format: sign[15], exp[14:9] bias 31, mant[8:0]).

---
 rtl/dlfloat_pkg.sv | 50 +++++
 rtl/dlf16_add.sv | 55 +++++
 rtl/dlfloat_dot_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: DLFloat16 (1-6-9, bias 31) constants, engine FSM states and the lane multiplier.
// dlf16_mul_flags is only built when DLFMAC_STATUS_EN is defined.
package dlfloat_pkg;

    localparam int EXP_W  = 6;
    localparam int MANT_W = 9;
    localparam int BIAS   = 31;

    localparam logic [15:0] POS_MAX = 16'h7DFE;
    localparam logic [15:0] NEG_MAX = 16'hFDFE;
    localparam logic [15:0] INF     = 16'hFFFF;
    localparam logic [15:0] POS_MIN = 16'h0201;
    localparam logic [15:0] NEG_MIN = 16'h8201;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    // Truncating multiply; a carry out of the mantissa product that pushes exp to 63 saturates.
    function automatic logic [15:0] dlf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [6:0]  es;
        logic [6:0]  e;
        logic [19:0] p;
        logic [10:0] ph;
        s  = a[15] ^ b[15];
        es = {1'b0, a[14:9]} + {1'b0, b[14:9]};
        p  = {10'b0, 1'b1, a[8:0]} * {10'b0, 1'b1, b[8:0]};
        ph = 11'(p >> 9);
        e  = es - 7'(BIAS) + {6'b0, ph[10]};
        if (a[14:9] == '0 || b[14:9] == '0 || es <= 7'(BIAS)) return 16'h0000;
        if (es == 7'd94) return INF;
        if (es > 7'd94 || e >= 7'd63) return s ? NEG_MAX : POS_MAX;
        return {s, e[5:0], ph[10] ? ph[9:1] : ph[8:0]};
    endfunction

`ifdef DLFMAC_STATUS_EN
    // {inf, ovf, unf} raised by the corresponding dlf16_mul call
    function automatic logic [2:0] dlf16_mul_flags(input logic [15:0] a, input logic [15:0] b);
        logic       z;
        logic       top;
        logic [6:0] es;
        z   = a[14:9] == '0 || b[14:9] == '0;
        es  = {1'b0, a[14:9]} + {1'b0, b[14:9]};
        top = ({10'b0, 1'b1, a[8:0]} * {10'b0, 1'b1, b[8:0]}) >= 20'h80000;
        return {!z && es == 7'd94,
                !z && es != 7'd94 && (es > 7'd94 || (es == 7'd93 && top)),
                !z && es <= 7'(BIAS)};
    endfunction
`endif

endpackage

// File: rtl/dlf16_add.sv
// dlf16_add: combinational DLFloat16 adder, truncating after alignment and normalisation.
// The flags port ({inf, ovf, unf}) exists only when DLFMAC_STATUS_EN is defined.
module dlf16_add
    import dlfloat_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
`ifdef DLFMAC_STATUS_EN
    output logic [2:0]  flags,
`endif
    output logic [15:0] y
);

    logic        swap;
    logic        sub;
    logic [15:0] x;
    logic [15:0] w;
    logic [9:0]  mw;
    logic [10:0] s;
    logic [8:0]  norm;
    logic [3:0]  lz;
    logic [7:0]  e;
    logic        ovf;
    logic        unf;

    // x is the larger magnitude, so the result sign is always x's sign
    always_comb begin
        swap = b[14:0] > a[14:0];
        x    = swap ? b : a;
        w    = swap ? a : b;
        mw   = {1'b1, w[8:0]} >> (x[14:9] - w[14:9]);
        sub  = x[15] ^ w[15];
        s    = sub ? {1'b0, 1'b1, x[8:0]} - {1'b0, mw} : {1'b0, 1'b1, x[8:0]} + {1'b0, mw};
        lz   = 4'd0;
        for (int i = 0; i < 10; i++) if (s[i]) lz = 4'(9 - i);
        norm = 9'(s[9:0] << lz);
        e    = s[10] ? {2'b0, x[14:9]} + 8'd1 : {2'b0, x[14:9]} - {4'b0, lz};
        ovf  = !e[7] && e >= 8'd63;
        unf  = e[7] || e == 8'd0;
        if (a == INF || b == INF) y = INF;
        else if (a[14:9] == '0) y = b;
        else if (b[14:9] == '0) y = a;
        else if (s == '0) y = 16'h0000;
        else if (ovf) y = x[15] ? NEG_MAX : POS_MAX;
        else if (unf) y = x[15] ? NEG_MIN : POS_MIN;
        else y = {x[15], e[5:0], s[10] ? s[9:1] : norm};
    end

`ifdef DLFMAC_STATUS_EN
    logic regular;
    assign regular = a != INF && b != INF && a[14:9] != '0 && b[14:9] != '0 && s != '0;
    assign flags   = {y == INF, regular && ovf, regular && !ovf && unf};
`endif

endmodule

// File: rtl/dlfloat_dot_engine.sv
// dlfloat_dot_engine: streaming DLFloat16 dot product, LANES products per beat, one result per vector.
// Define DLFMAC_STATUS_EN to build the sticky {inf, ovf, unf} status; otherwise out_status is 0.
module dlfloat_dot_engine
    import dlfloat_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_a,
    input  logic [16*LANES-1:0]   in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  out_len_err,
    output logic [2:0]            out_status
);

    localparam int N = 2 * LANES - 1;

    state_t           state_q;
    state_t           state_d;
    logic             adv;
    logic             beat;
    logic             last_eff;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      p [LANES];
    logic             p_valid;
    logic             p_last;
    logic             p_len_err;
    logic [15:0]      node [N];
    logic [15:0]      acc;
    logic [15:0]      acc_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign beat     = in_valid && in_ready;
    assign last_eff = in_last || cnt == CNT_W'(MAX_LEN - 1);

    always_comb begin
        state_d = state_q;
        if (!adv) state_d = HOLD;
        else if (beat) state_d = last_eff ? IDLE : ACC;
        else if (state_q == HOLD) state_d = (cnt != '0) ? ACC : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (beat) cnt <= last_eff ? '0 : cnt + 1'b1;
        end
    end

    // Stage 1: lane products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_len_err <= 1'b0;
            for (int i = 0; i < LANES; i++) p[i] <= 16'h0000;
        end else if (adv) begin
            p_valid   <= beat;
            p_last    <= last_eff;
            p_len_err <= !in_last && last_eff;
            for (int i = 0; i < LANES; i++) p[i] <= dlf16_mul(in_a[16*i +: 16], in_b[16*i +: 16]);
        end
    end

    // Heap-ordered adder tree: leaves at LANES-1.., root at node[0]
    for (genvar l = 0; l < LANES; l++) begin : g_leaf
        assign node[LANES-1+l] = p[l];
    end

`ifdef DLFMAC_STATUS_EN
    logic [2:0] pf [LANES];
    logic [2:0] nf [N];
    logic [2:0] acc_f;
    logic [2:0] st;
    logic [2:0] st_all;

    for (genvar l = 0; l < LANES; l++) begin : g_leaf_f
        assign nf[LANES-1+l] = pf[l];
    end
`endif

    for (genvar j = 0; j < LANES - 1; j++) begin : g_tree
`ifdef DLFMAC_STATUS_EN
        logic [2:0] f;
        assign nf[j] = f | nf[2*j+1] | nf[2*j+2];
`endif
        dlf16_add u_add (
            .a     (node[2*j+1]),
            .b     (node[2*j+2]),
`ifdef DLFMAC_STATUS_EN
            .flags (f),
`endif
            .y     (node[j])
        );
    end

    dlf16_add u_acc (
        .a     (acc),
        .b     (node[0]),
`ifdef DLFMAC_STATUS_EN
        .flags (acc_f),
`endif
        .y     (acc_sum)
    );

    // Stage 2: accumulate; the closing beat loads the result and clears acc in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= 16'h0000;
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            out_len_err <= 1'b0;
        end else if (adv) begin
            out_valid <= p_valid && p_last;
            if (p_valid) acc <= p_last ? 16'h0000 : acc_sum;
            if (p_valid && p_last) begin
                out_data    <= acc_sum;
                out_len_err <= p_len_err;
            end
        end
    end

`ifdef DLFMAC_STATUS_EN
    assign st_all = st | nf[0] | acc_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= 3'b000;
            out_status <= 3'b000;
            for (int i = 0; i < LANES; i++) pf[i] <= 3'b000;
        end else if (adv) begin
            for (int i = 0; i < LANES; i++) pf[i] <= dlf16_mul_flags(in_a[16*i +: 16], in_b[16*i +: 16]);
            if (p_valid) st <= p_last ? 3'b000 : st_all;
            if (p_valid && p_last) out_status <= st_all;
        end
    end
`else
    assign out_status = 3'b000;
`endif

endmodule
